mux_select_ctrl: RTL
====================

MUX_SELECT_CTRL -- requirements
Module: mux_select_ctrl

Interface
REQ-001 SHALL have parameter NUM_BTN, default 5, number of select buttons (2..32).
REQ-002 SHALL have parameter SEL_W, default $clog2(NUM_BTN), width of select output.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 4, stable cycles required before a button level is accepted (1..65535).
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port buttons, input, NUM_BTN, raw asynchronous button levels, bit i selects channel i.
REQ-007 SHALL have port lock, input, 1, asynchronous level; high freezes current selection.
REQ-008 SHALL have port sel, output, SEL_W, registered selected channel index.
REQ-009 SHALL have port sel_valid, output, 1, high once any selection has been accepted since reset.
REQ-010 SHALL have port sel_changed, output, 1, one-cycle pulse when sel takes a new value.

Function
REQ-011 SHALL pass buttons and lock each through a 2-flop synchroniser before any use.
REQ-012 SHALL derive per-button press event = rising edge of the (debounced, if enabled) synchronised level; a held button yields exactly one event.
REQ-013 SHALL, on events from several buttons in the same cycle, accept the lowest index only; other events that cycle are discarded.
REQ-014 SHALL register sel = accepted index on the edge following the event cycle; sel_valid set to 1 on the same edge.
REQ-015 SHALL pulse sel_changed for one cycle on that edge only if the new index differs from the previous sel or sel_valid was 0.
REQ-016 SHALL discard (not queue) all press events while synchronised lock is 1; sel, sel_valid hold.
REQ-017 SHALL, on lock falling, not re-evaluate buttons already held; only new rising edges select.
REQ-018 SHALL leave sel unchanged when no event occurs, including buttons released to all-zero.
REQ-019 SHALL, without debounce, update sel on the 3rd rising clk edge after a button rises (2 sync + 1 register).

Reset
REQ-020 SHALL, while reset high, force sel=0, sel_valid=0, sel_changed=0, synchroniser flops, debounced levels, edge history and debounce counters to 0, independent of clk.
REQ-021 SHALL, on reset mid-debounce or mid-lock, discard all partial state; buttons held across reset release yield an event only after satisfying debounce from 0.

Configuration
REQ-022 SHALL, with macro MUX_SELECT_DEBOUNCE_EN defined, per button hold a counter that increments while synchronised level != debounced level, clears when equal, and toggles debounced level when count reaches DEBOUNCE_CYCLES; sel latency = 3 + DEBOUNCE_CYCLES edges.
REQ-023 SHALL, without MUX_SELECT_DEBOUNCE_EN, omit counters entirely; debounced level = synchronised level; DEBOUNCE_CYCLES ignored.
REQ-024 SHALL, with debounce enabled, ignore glitches shorter than DEBOUNCE_CYCLES cycles (counter clears on return).

Structure
REQ-025 SHALL place DEBOUNCE counter width constant (16) and priority-encoder function in shared package mux_ctrl_pkg.
REQ-026 SHALL implement per-button sync+debounce as sub-module btn_debounce, instantiated NUM_BTN times via generate.

Verification
REQ-027 SHALL verify: reset, no buttons -> sel=0, sel_valid=0, sel_changed=0 for 20 cycles.
REQ-028 SHALL verify: buttons=5'b00100 held 10 cycles (no debounce) -> sel=2 at 3rd edge, sel_changed one pulse, sel_valid=1, no further pulses.
REQ-029 SHALL verify: buttons 0 -> 5'b10111 in one cycle -> sel=0; then 5'b01100 after release -> sel=2.
REQ-030 SHALL verify: lock=1, buttons=5'b01000 pulsed -> sel unchanged, sel_changed=0; lock=0 with button held -> no change.
REQ-031 SHALL verify with MUX_SELECT_DEBOUNCE_EN, DEBOUNCE_CYCLES=4: 3-cycle pulse on bit 1 -> ignored; 8-cycle hold on bit 1 -> sel=1 at edge 7.
REQ-032 SHALL verify: reset asserted mid-debounce on bit 4 -> outputs 0 immediately; held bit 4 after release -> sel=4 after full latency.

Source files
------------

// File: rtl/mux_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_ctrl_pkg : shared constants and lowest-index priority encoder    |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package mux_ctrl_pkg;

   localparam int DB_CNT_W   = 16;
   localparam int PRIO_VEC_W = 32;
   localparam int PRIO_IDX_W = 5;

   typedef logic [DB_CNT_W-1:0] db_cnt_t;

   // Lowest set bit wins; returns 0 for an all-zero vector (caller gates on |vec).
   function automatic logic [PRIO_IDX_W-1:0] lowest_set_idx(input logic [PRIO_VEC_W-1:0] vec_i);
      logic [PRIO_IDX_W-1:0] idx;
      logic                  found;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < PRIO_VEC_W; i++) begin
         if (vec_i[i] && !found) begin
            idx   = PRIO_IDX_W'(i);
            found = 1'b1;
         end
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mux_select_ctrl_btn_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_debounce : 2-flop sync, optional debounce, rising-edge press     |
// | Option       : MUX_SELECT_DEBOUNCE_EN enables the stability counter  |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module btn_debounce
   import mux_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_i,
   output logic press_o
);

   logic [1:0] sync_q;
   logic       level;
   logic       prev_q;

   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_cfg
      $error("btn_debounce: DEBOUNCE_CYCLES out of range 1..65535");
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], btn_i};
         prev_q <= level;
      end
   end

`ifdef MUX_SELECT_DEBOUNCE_EN
   logic    db_q;
   db_cnt_t cnt_q;

   // The count only advances while the synchronised level disagrees, so any
   // return to the accepted level before the limit discards the glitch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         db_q  <= 1'b0;
         cnt_q <= '0;
      end else if (sync_q[1] != db_q) begin
         if (cnt_q == db_cnt_t'(DEBOUNCE_CYCLES - 1)) begin
            db_q  <= ~db_q;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + db_cnt_t'(1);
         end
      end else begin
         cnt_q <= '0;
      end
   end

   assign level = db_q;
`else
   assign level = sync_q[1];
`endif

   assign press_o = level & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/mux_select_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_select_ctrl : button-driven channel select with lock             |
// | Option          : MUX_SELECT_DEBOUNCE_EN (see btn_debounce)          |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module mux_select_ctrl
   import mux_ctrl_pkg::*;
#(
   parameter int          NUM_BTN         = 5,
   parameter int          SEL_W           = $clog2(NUM_BTN),
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_BTN-1:0] buttons,
   input  logic               lock,
   output logic [SEL_W-1:0]   sel,
   output logic               sel_valid,
   output logic               sel_changed
);

   logic [NUM_BTN-1:0] press;
   logic [1:0]         lock_sync_q;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic               valid_q, valid_d;
   logic               changed_q, changed_d;
   logic [SEL_W-1:0]   win_idx;

   if (NUM_BTN < 2 || NUM_BTN > PRIO_VEC_W) begin : g_bad_cfg
      $error("mux_select_ctrl: NUM_BTN out of range 2..32");
   end

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_btn (
         .clk     (clk),
         .reset   (reset),
         .btn_i   (buttons[i]),
         .press_o (press[i])
      );
   end

   assign win_idx = SEL_W'(lowest_set_idx(PRIO_VEC_W'(press)));

   // Edge history keeps tracking while locked, so buttons held through the
   // lock produce no event once it drops.
   always_comb begin
      sel_d     = sel_q;
      valid_d   = valid_q;
      changed_d = 1'b0;
      if ((|press) && !lock_sync_q[1]) begin
         sel_d     = win_idx;
         valid_d   = 1'b1;
         changed_d = !valid_q || (win_idx != sel_q);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lock_sync_q <= '0;
         sel_q       <= '0;
         valid_q     <= 1'b0;
         changed_q   <= 1'b0;
      end else begin
         lock_sync_q <= {lock_sync_q[0], lock};
         sel_q       <= sel_d;
         valid_q     <= valid_d;
         changed_q   <= changed_d;
      end
   end

   assign sel         = sel_q;
   assign sel_valid   = valid_q;
   assign sel_changed = changed_q;

endmodule
`default_nettype wire
